// File: rtl/rs_kes_arb.sv
// Two-lane round-robin front end for a shared Reed-Solomon key-equation solver.
// It holds one request in flight, bypasses all-zero syndromes and times out a silent solver.
module rs_kes_arb #(
  parameter int unsigned TMO_CYC = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  input  logic [31:0] req0_syn,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_syn,
  output logic        req1_ready,
  output logic        kes_ena,
  output logic [7:0]  kes_syn0,
  output logic [7:0]  kes_syn1,
  output logic [7:0]  kes_syn2,
  output logic [7:0]  kes_syn3,
  input  logic        kes_done,
  input  logic [7:0]  kes_lambda0,
  input  logic [7:0]  kes_lambda1,
  input  logic [7:0]  kes_lambda2,
  input  logic [7:0]  kes_omega0,
  input  logic [7:0]  kes_omega1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_lane,
  output logic [23:0] res_lambda,
  output logic [15:0] res_omega,
  output logic        res_err,
  output logic        res_tmo
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic        lane_q;
  logic [31:0] syn_q;
  logic [7:0]  cnt_q;
  logic [23:0] lambda_q;
  logic [15:0] omega_q;
  logic        err_q;
  logic        tmo_q;

  logic        grant;
  logic [31:0] sel_syn;
  logic        accept;
  logic        tmo_hit;

  // Contention alternates away from the last served lane; a lone requester always wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    sel_syn = grant ? req1_syn : req0_syn;
  end

  assign accept  = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign tmo_hit = (cnt_q == 8'(TMO_CYC));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = (|sel_syn) ? S_LAUNCH : S_HOLD;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (kes_done || tmo_hit) state_d = S_HOLD;
      S_HOLD:   if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Readys are gated by rstn so a pending request is never acknowledged while in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    kes_ena    = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req0_ready = rstn & ~grant;
        req1_ready = rstn & grant;
      end
      S_LAUNCH: kes_ena   = 1'b1;
      S_HOLD:   res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      lane_q       <= 1'b0;
      syn_q        <= '0;
      cnt_q        <= '0;
      lambda_q     <= '0;
      omega_q      <= '0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_WAIT) ? cnt_q + 8'd1 : '0;
      if (accept) begin
        syn_q        <= sel_syn;
        lane_q       <= grant;
        last_grant_q <= grant;
        if (~|sel_syn) begin
          lambda_q <= 24'h000001;
          omega_q  <= '0;
          err_q    <= 1'b0;
          tmo_q    <= 1'b0;
        end
      end
      if (state_q == S_WAIT) begin
        if (kes_done) begin
          lambda_q <= {kes_lambda2, kes_lambda1, kes_lambda0};
          omega_q  <= {kes_omega1, kes_omega0};
          err_q    <= 1'b1;
          tmo_q    <= 1'b0;
        end else if (tmo_hit) begin
          lambda_q <= '0;
          omega_q  <= '0;
          err_q    <= 1'b1;
          tmo_q    <= 1'b1;
        end
      end
    end
  end

  assign kes_syn0   = syn_q[7:0];
  assign kes_syn1   = syn_q[15:8];
  assign kes_syn2   = syn_q[23:16];
  assign kes_syn3   = syn_q[31:24];
  assign res_lane   = lane_q;
  assign res_lambda = lambda_q;
  assign res_omega  = omega_q;
  assign res_err    = err_q;
  assign res_tmo    = tmo_q;

endmodule

// File: tb/tb_rs_kes_arb.sv
// Directed bench for rs_kes_arb: solver behaviour is scripted per request with hand-computed results.
module tb_rs_kes_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_syn, req1_syn;
  logic        kes_ena, kes_done;
  logic [7:0]  kes_syn0, kes_syn1, kes_syn2, kes_syn3;
  logic [7:0]  kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1;
  logic        res_valid, res_ready, res_lane, res_err, res_tmo;
  logic [23:0] res_lambda;
  logic [15:0] res_omega;

  int n_tests = 0;
  int n_fail  = 0;

  rs_kes_arb #(.TMO_CYC(8)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_syn(req0_syn), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_syn(req1_syn), .req1_ready(req1_ready),
    .kes_ena(kes_ena), .kes_syn0(kes_syn0), .kes_syn1(kes_syn1),
    .kes_syn2(kes_syn2), .kes_syn3(kes_syn3), .kes_done(kes_done),
    .kes_lambda0(kes_lambda0), .kes_lambda1(kes_lambda1), .kes_lambda2(kes_lambda2),
    .kes_omega0(kes_omega0), .kes_omega1(kes_omega1),
    .res_valid(res_valid), .res_ready(res_ready), .res_lane(res_lane),
    .res_lambda(res_lambda), .res_omega(res_omega), .res_err(res_err), .res_tmo(res_tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns once a ready is seen (just before the accepting edge).
  task automatic accept(input logic v0, input logic v1, input logic [31:0] s0,
                        input logic [31:0] s1, output int lane, output int waited);
    req0_valid = v0; req1_valid = v1; req0_syn = s0; req1_syn = s1;
    lane = -1;
    waited = 0;
    for (int k = 0; k < 20 && lane < 0; k++) begin
      #1;
      if (req0_ready || req1_ready) lane = req1_ready ? 1 : 0;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    if (lane < 0) chk("accept_bound", 0, 1);
  endtask

  // Step cycles after the accepting edge; j counts cycles after accept.
  task automatic serve(input logic launch, input logic [31:0] syn, input int done_j,
                       input logic [23:0] lam, input logic [15:0] om,
                       input logic keep_valid, output int res_j);
    res_j = 0;
    for (int j = 1; j <= 40 && res_j == 0; j++) begin
      @(negedge clk);
      if (j == 1 && !keep_valid) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      kes_done    = (j == done_j);
      kes_lambda0 = (j == done_j) ? lam[7:0]   : 8'hEE;
      kes_lambda1 = (j == done_j) ? lam[15:8]  : 8'hEE;
      kes_lambda2 = (j == done_j) ? lam[23:16] : 8'hEE;
      kes_omega0  = (j == done_j) ? om[7:0]    : 8'hEE;
      kes_omega1  = (j == done_j) ? om[15:8]   : 8'hEE;
      #1;
      if (j == 1) begin
        chk("kes_ena_launch", kes_ena, launch);
        chk("ready_busy", {req0_ready, req1_ready}, 0);
        if (launch) chk("kes_syn", {kes_syn3, kes_syn2, kes_syn1, kes_syn0}, syn);
      end else if (kes_ena) chk("kes_ena_extra", kes_ena, 0);
      if (j == done_j) chk("kes_syn_wait", {kes_syn3, kes_syn2, kes_syn1, kes_syn0}, syn);
      if (res_valid) res_j = j;
    end
    kes_done = 1'b0;
    if (res_j == 0) chk("res_bound", 0, 1);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    chk("res_valid_drop", res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lane, waited, rj;
    rstn = 1'b0; res_ready = 1'b0; kes_done = 1'b0;
    kes_lambda0 = '0; kes_lambda1 = '0; kes_lambda2 = '0; kes_omega0 = '0; kes_omega1 = '0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_syn = 32'h0000_00AA; req1_syn = 32'h0000_00BB;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_kes_ena", kes_ena, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_kes_syn", {kes_syn3, kes_syn2, kes_syn1, kes_syn0}, 0);
    chk("rst_res_data", {res_lambda, res_lane, res_err, res_tmo}, 0);
    chk("rst_res_omega", res_omega, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Both lanes valid continuously: grants 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      accept(1'b1, 1'b1, 32'h0000_00AA, 32'h0000_00BB, lane, waited);
      chk("rr_grant", lane, i % 2);
      serve(1'b1, (i % 2) ? 32'h0000_00BB : 32'h0000_00AA, 6, 24'h010203, 16'h0405, 1'b1, rj);
      chk("rr_lat", rj, 7);
      chk("rr_lane", res_lane, i % 2);
      take_result();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Nominal lane0 request, 5-cycle solver.
    accept(1'b1, 1'b0, 32'h0403_0201, 32'h0, lane, waited);
    chk("nom_grant", lane, 0);
    serve(1'b1, 32'h0403_0201, 6, 24'h00A501, 16'h3C01, 1'b0, rj);
    chk("nom_lat", rj, 7);
    chk("nom_lane", res_lane, 0);
    chk("nom_lambda", res_lambda, 24'h00A501);
    chk("nom_omega", res_omega, 16'h3C01);
    chk("nom_err_tmo", {res_err, res_tmo}, 2'b10);
    take_result();

    // Lane1 zero syndromes: bypass.
    accept(1'b0, 1'b1, 32'h0, 32'h0, lane, waited);
    chk("byp_grant", lane, 1);
    serve(1'b0, 32'h0, 0, 24'h0, 16'h0, 1'b0, rj);
    chk("byp_lat", rj, 1);
    chk("byp_lane", res_lane, 1);
    chk("byp_lambda", res_lambda, 24'h000001);
    chk("byp_omega", res_omega, 0);
    chk("byp_err_tmo", {res_err, res_tmo}, 0);
    take_result();

    // Done arriving exactly at the timeout count wins.
    accept(1'b1, 1'b0, 32'h0000_0100, 32'h0, lane, waited);
    serve(1'b1, 32'h0000_0100, 10, 24'h123456, 16'hBEEF, 1'b0, rj);
    chk("edge_lat", rj, 11);
    chk("edge_lambda", res_lambda, 24'h123456);
    chk("edge_omega", res_omega, 16'hBEEF);
    chk("edge_err_tmo", {res_err, res_tmo}, 2'b10);
    take_result();

    // Silent solver: timeout.
    accept(1'b0, 1'b1, 32'h0, 32'h0000_0010, lane, waited);
    serve(1'b1, 32'h0000_0010, 0, 24'h0, 16'h0, 1'b0, rj);
    chk("tmo_lat", rj, 11);
    chk("tmo_lane", res_lane, 1);
    chk("tmo_lambda", res_lambda, 0);
    chk("tmo_omega", res_omega, 0);
    chk("tmo_err_tmo", {res_err, res_tmo}, 2'b11);
    @(negedge clk);
    req0_valid = 1'b1; req0_syn = 32'h0;
    #1;
    chk("tmo_hold_ready", {req0_ready, req1_ready}, 0);
    take_result();
    accept(1'b1, 1'b0, 32'h0, 32'h0, lane, waited);
    chk("tmo_next_wait", waited, 0);

    // Bypass result then stall with res_ready low, stray kes_done included.
    serve(1'b0, 32'h0, 0, 24'h0, 16'h0, 1'b1, rj);
    chk("stall_lat", rj, 1);
    req1_valid = 1'b1; req1_syn = 32'h0000_0055;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      kes_done = (c == 0);
      kes_lambda0 = 8'h77; kes_lambda1 = 8'h77; kes_lambda2 = 8'h77;
      kes_omega0 = 8'h77; kes_omega1 = 8'h77;
      #1;
      chk("stall_valid", res_valid, 1);
      chk("stall_data", {res_lambda, res_lane, res_err, res_tmo}, {24'h000001, 1'b0, 2'b00});
      chk("stall_omega", res_omega, 0);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
      chk("stall_kes_ena", kes_ena, 0);
    end
    kes_done = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    take_result();

    // Reset at N+3 abandons the request; later kes_done ignored.
    accept(1'b1, 1'b0, 32'h0403_0201, 32'h0, lane, waited);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_outs", {kes_ena, res_valid, req0_ready, req1_ready}, 0);
    chk("mid_rst_syn", {kes_syn3, kes_syn2, kes_syn1, kes_syn0}, 0);
    chk("mid_rst_res", {res_lambda, res_lane, res_err, res_tmo}, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    kes_done = 1'b1;
    kes_lambda0 = 8'h11; kes_lambda1 = 8'h22; kes_lambda2 = 8'h33;
    kes_omega0 = 8'h44; kes_omega1 = 8'h55;
    @(negedge clk);
    kes_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stray_valid", res_valid, 0);
      chk("stray_ena", kes_ena, 0);
      chk("stray_res", res_lambda, 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_kes_arb.md
RS_KES_ARB -- requirements
Module: rs_kes_arb

Interface
REQ-001 Parameter TMO_CYC, default 8, max cycles to wait for kes_done after kes_ena before declaring timeout (range 6..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  lane 0/1 has a syndrome set pending.
REQ-005 req0_syn / req1_syn  input  32  {S3,S2,S1,S0}, S0 in bits [7:0].
REQ-006 req0_ready / req1_ready  output  1  lane 0/1 request accepted this cycle when valid&ready.
REQ-007 kes_ena  output  1  one-cycle start pulse to the key-equation solver.
REQ-008 kes_syn0..kes_syn3  output  8 each  syndromes driven to the solver.
REQ-009 kes_done  input  1  solver result-valid pulse.
REQ-010 kes_lambda0..2, kes_omega0..1  input  8 each  solver results, valid while kes_done=1.
REQ-011 res_valid  output  1  result available; res_ready  input  1  consumer accepts.
REQ-012 res_lane  output  1  lane that issued the result.
REQ-013 res_lambda  output  24  {L2,L1,L0}; res_omega  output  16  {O1,O0}.
REQ-014 res_err  output  1  syndromes nonzero; res_tmo  output  1  solver timed out.

Function
REQ-015 FSM states IDLE, LAUNCH, WAIT, HOLD; one request in flight at a time.
REQ-016 IDLE: reqN_ready=1 only for the granted lane, 0 for the other; in all other states both readys=0.
REQ-017 Grant: only one lane valid -> that lane; both valid -> lane other than last_grant (round robin); last_grant updates on each accepted handshake.
REQ-018 On accept (cycle N): register syndromes and lane id; any syndrome nonzero -> LAUNCH at N+1, else -> HOLD at N+1 (bypass).
REQ-019 Bypass result: res_lambda=24'h000001, res_omega=0, res_err=0, res_tmo=0; solver is not started.
REQ-020 LAUNCH: kes_ena=1 for exactly one cycle; then WAIT.
REQ-021 kes_syn0..3 shall equal the registered syndromes from LAUNCH until leaving WAIT; reset value 0.
REQ-022 WAIT: 8-bit counter cleared on entry, increments per cycle; kes_done=1 -> capture lambda/omega, res_err=1, res_tmo=0, go HOLD next cycle.
REQ-023 WAIT: counter reaches TMO_CYC with kes_done=0 -> HOLD with res_lambda=0, res_omega=0, res_err=1, res_tmo=1.
REQ-024 kes_done in the same cycle the counter reaches TMO_CYC -> treated as normal completion (done wins).
REQ-025 kes_done outside WAIT is ignored; no output changes.
REQ-026 Nominal latency with a 5-cycle solver: kes_done at N+6, res_valid at N+7.
REQ-027 HOLD: res_valid=1, all res_* stable until res_valid&res_ready; then IDLE next cycle; next accept no earlier than that cycle.
REQ-028 res_valid shall be 0 in every state except HOLD.

Reset
REQ-029 rstn low: state IDLE, kes_ena=0, res_valid=0, both readys=0 during reset, all data outputs 0, counter 0, last_grant=1 (lane 0 wins first contention).
REQ-030 Reset asserted mid-WAIT or mid-HOLD abandons the request; a later stray kes_done is ignored per REQ-025.

Verification
REQ-031 Lane0 syn={04,03,02,01}, solver done 5 cycles after kes_ena with L={00,A5,01}, O={3C,01} -> kes_ena at N+1, res_valid N+7, res_lane=0, res_lambda=24'h00A501, res_omega=16'h3C01, res_err=1.
REQ-032 Lane1 syn=0 -> no kes_ena, res_valid at N+1, res_lambda=24'h000001, res_omega=0, res_err=0.
REQ-033 Both lanes valid continuously after reset, nonzero syndromes -> grants 0,1,0,1; each lane served once per two results.
REQ-034 Solver never asserts kes_done, TMO_CYC=8 -> res_valid with res_tmo=1, res_lambda=0; next request accepted after res_ready.
REQ-035 res_ready held 0 for 10 cycles in HOLD -> res_* stable, both readys 0, kes_ena 0 throughout.
REQ-036 rstn pulsed low at cycle N+3 of a request -> all outputs 0 immediately; kes_done at N+6 ignored; res_valid stays 0.
